// File: rtl/morsecode_controller.sv
// Sends one Morse letter (A..H) through an external 13-bit shift register:
// parallel-loads the letter pattern, then shifts once per Morse unit.
`timescale 1ns/1ps
module morsecode_controller #(
  parameter int TICK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  letter,
  input  logic        sr_bit0,
  output logic [12:0] sr_data,
  output logic        sr_enable,
  output logic        sr_shift,
  output logic        led,
  output logic        busy,
  output logic        done
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] COUNT_MAX = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [3:0]      bits_reg, bits_next;
  logic [2:0]      letter_reg, letter_next;
  logic            loaded_reg, loaded_next;
  logic [12:0]     pattern;
  logic [3:0]      length;
  logic            unit_end;

  // Pattern is sent LSB first; 1 = light on for one unit.
  always_comb begin
    pattern = 13'h0000;
    length  = 4'd0;
    case (letter_reg)
      3'd0: begin pattern = 13'h001D; length = 4'd5;  end
      3'd1: begin pattern = 13'h0157; length = 4'd9;  end
      3'd2: begin pattern = 13'h05D7; length = 4'd11; end
      3'd3: begin pattern = 13'h0057; length = 4'd7;  end
      3'd4: begin pattern = 13'h0001; length = 4'd1;  end
      3'd5: begin pattern = 13'h0175; length = 4'd9;  end
      3'd6: begin pattern = 13'h0177; length = 4'd9;  end
      default: begin pattern = 13'h0055; length = 4'd7; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      bits_reg   <= 4'd0;
      letter_reg <= 3'd0;
      loaded_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      bits_reg   <= bits_next;
      letter_reg <= letter_next;
      loaded_reg <= loaded_next;
    end
  end

  assign unit_end = (state_reg == SHOW) && (count_reg == COUNT_MAX);

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    bits_next   = bits_reg;
    letter_next = letter_reg;
    loaded_next = loaded_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          letter_next = letter;
          loaded_next = 1'b1;
          state_next  = LOAD;
        end
      end
      LOAD: begin
        count_next = '0;
        bits_next  = length;
        state_next = SHOW;
      end
      SHOW: begin
        if (count_reg == COUNT_MAX) begin
          count_next = '0;
          bits_next  = bits_reg - 4'd1;
          if (bits_reg == 4'd1) state_next = IDLE;
        end else begin
          count_next = count_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // sr_data holds 0 until a letter has been accepted since reset.
  assign sr_data   = loaded_reg ? pattern : 13'h0000;
  assign sr_enable = (state_reg == LOAD);
  assign sr_shift  = unit_end;
  assign done      = unit_end && (bits_reg == 4'd1);
  assign busy      = (state_reg != IDLE);
  assign led       = (state_reg == SHOW) & sr_bit0;
endmodule

// File: tb/tb_morsecode_controller.sv
// Bench for morsecode_controller: timing model derived from letter start cycle,
// external shift register model, and directed letter scenarios.
`timescale 1ns/1ps
module tb_morsecode_controller;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  letter = 3'd0;
  logic        sr_bit0;
  logic [12:0] sr_data;
  logic        sr_enable, sr_shift, led, busy, done;

  morsecode_controller #(.TICK_DIV(T)) dut (
    .clk(clk), .reset(reset), .start(start), .letter(letter),
    .sr_bit0(sr_bit0), .sr_data(sr_data), .sr_enable(sr_enable),
    .sr_shift(sr_shift), .led(led), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // External shift register driven by the DUT strobes.
  logic [12:0] sreg = 13'h0000;
  always @(posedge clk) begin
    if (sr_enable)     sreg <= sr_data;
    else if (sr_shift) sreg <= sreg >> 1;
  end
  assign sr_bit0 = sreg[0];

  logic [12:0] pat_tab [8] = '{13'h001D, 13'h0157, 13'h05D7, 13'h0057,
                               13'h0001, 13'h0175, 13'h0177, 13'h0055};
  int          len_tab [8] = '{5, 9, 11, 7, 1, 9, 9, 7};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Model: a letter accepted in cycle c occupies cycles c+1 .. c+1+L*T.
  bit          m_active = 1'b0;
  bit          m_have = 1'b0;
  int          m_t0 = 0;
  int          m_len = 0;
  logic [12:0] m_pat = 13'h0000;

  int shift_q[$];
  int done_q[$];
  int en_q[$];
  int en_data_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      m_have   = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_have   = 1'b1;
        m_t0     = cyc + 1;
        m_len    = len_tab[letter];
        m_pat    = pat_tab[letter];
      end
    end else if (cyc == m_t0 + m_len * T) begin
      m_active = 1'b0;
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      int  rel;
      bit  e_en, e_shift, e_done, e_busy, e_show;
      rel     = cyc - m_t0;
      e_busy  = m_active;
      e_en    = m_active && rel == 0;
      e_show  = m_active && rel >= 1;
      e_shift = e_show && (rel % T) == 0;
      e_done  = e_show && rel == m_len * T;
      check("sr_enable", int'(sr_enable), int'(e_en));
      check("sr_shift",  int'(sr_shift),  int'(e_shift));
      check("done",      int'(done),      int'(e_done));
      check("busy",      int'(busy),      int'(e_busy));
      check("led",       int'(led),       e_show ? int'(sr_bit0) : 0);
      check("sr_data",   int'(sr_data),   m_have ? int'(m_pat) : 0);
      if (sr_shift)  shift_q.push_back(cyc);
      if (done)      done_q.push_back(cyc);
      if (sr_enable) begin
        en_q.push_back(cyc);
        en_data_q.push_back(int'(sr_data));
      end
    end
  end

  task automatic clear_logs();
    shift_q.delete();
    done_q.delete();
    en_q.delete();
    en_data_q.delete();
  endtask

  task automatic goto(input int n);
    int k = 0;
    while (cyc != n && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (cyc != n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL goto timeout: at cycle %0d, wanted cycle %0d", cyc, n);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle timeout: busy still 1, required 0 at cycle %0d", cyc);
    end
  endtask

  task automatic send(input logic [2:0] l, input bit hold, output int base);
    wait_idle();
    letter = l;
    start  = 1'b1;
    base   = cyc;
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst busy", int'(busy), 0);
    check("rst sr_data", int'(sr_data), 0);
    check("rst led", int'(led), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle busy", int'(busy), 0);
    check("idle sr_enable", int'(sr_enable), 0);

    // Letter E
    clear_logs();
    send(3'd4, 1'b0, b);
    goto(b + 1);
    check("E enable", int'(sr_enable), 1);
    check("E sr_data", int'(sr_data), 'h0001);
    goto(b + 5);
    check("E shift", int'(sr_shift), 1);
    check("E done", int'(done), 1);
    goto(b + 6);
    check("E busy after", int'(busy), 0);
    @(negedge clk);
    check("E shift count", shift_q.size(), 1);
    $display("letter E: base %0d shifts %0d done %0d", b, shift_q.size(), done_q.size());

    // Letter A with led sequence 1,0,1,1,1
    clear_logs();
    send(3'd0, 1'b0, b);
    goto(b + 1);
    check("A sr_data", int'(sr_data), 'h001D);
    goto(b + 2);  check("A led u0", int'(led), 1);
    goto(b + 6);  check("A led u1", int'(led), 0);
    goto(b + 10); check("A led u2", int'(led), 1);
    goto(b + 14); check("A led u3", int'(led), 1);
    goto(b + 18); check("A led u4", int'(led), 1);
    goto(b + 23);
    check("A shift count", shift_q.size(), 5);
    if (shift_q.size() == 5)
      for (int i = 0; i < 5; i++) check("A shift cycle", shift_q[i] - b, 5 + 4 * i);
    check("A done count", done_q.size(), 1);
    if (done_q.size() == 1) check("A done cycle", done_q[0] - b, 21);
    $display("letter A: base %0d shifts %0d done %0d", b, shift_q.size(), done_q.size());

    // Letter C with start held: no restart until done, reload at cycle 46
    clear_logs();
    send(3'd2, 1'b1, b);
    goto(b + 46);
    check("C idle at 46", int'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    check("C reload enable", int'(sr_enable), 1);
    wait_idle();
    @(negedge clk);
    check("C shift count", shift_q.size(), 22);
    check("C done count", done_q.size(), 2);
    if (done_q.size() >= 1) check("C done cycle", done_q[0] - b, 45);
    check("C enable count", en_q.size(), 2);
    if (en_q.size() == 2) check("C second enable", en_q[1] - b, 47);
    $display("letter C x2: base %0d shifts %0d done %0d", b, shift_q.size(), done_q.size());

    // Letter B aborted by reset at cycle 10
    clear_logs();
    send(3'd1, 1'b0, b);
    goto(b + 10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("B rst busy", int'(busy), 0);
    check("B rst sr_data", int'(sr_data), 0);
    check("B rst enable", int'(sr_enable), 0);
    goto(b + 45);
    check("B still idle", int'(busy), 0);
    check("B shift count", shift_q.size(), 2);
    check("B done count", done_q.size(), 0);
    $display("letter B aborted: base %0d shifts %0d done %0d", b, shift_q.size(), done_q.size());

    // Letter G with letter input changing while busy, then H back-to-back
    clear_logs();
    send(3'd6, 1'b0, b);
    goto(b + 3);  letter = 3'd3;
    goto(b + 20); letter = 3'd5;
    goto(b + 21);
    check("G pattern held", int'(sr_data), 'h0177);
    goto(b + 37);
    check("G done", int'(done), 1);
    goto(b + 38);
    check("G idle", int'(busy), 0);
    start  = 1'b1;
    letter = 3'd7;
    @(negedge clk);
    start = 1'b0;
    check("H enable", int'(sr_enable), 1);
    check("H sr_data", int'(sr_data), 'h0055);
    wait_idle();
    $display("letters G,H: base %0d shifts %0d done %0d", b, shift_q.size(), done_q.size());

    // Sweep all letters
    for (int l = 0; l < 8; l++) begin
      clear_logs();
      send(3'(l), 1'b0, b);
      wait_idle();
      @(negedge clk);
      check("sweep enable count", en_data_q.size(), 1);
      if (en_data_q.size() == 1) check("sweep pattern", en_data_q[0], int'(pat_tab[l]));
      check("sweep shift count", shift_q.size(), len_tab[l]);
      check("sweep done count", done_q.size(), 1);
      $display("sweep letter %0d: shifts %0d done %0d", l, shift_q.size(), done_q.size());
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/morsecode_controller.md
MORSECODE_CONTROLLER -- requirements
Module: morsecode_controller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, meaning clk cycles per Morse unit (0.5 s at 50 MHz); legal range 2 and above.
REQ-002 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to send one letter; sampled only in IDLE.
REQ-005 SHALL have port letter, input, 3, letter select: 0=A, 1=B, ..., 7=H.
REQ-006 SHALL have port sr_bit0, input, 1, bit 0 of the external 13-bit shift register.
REQ-007 SHALL have port sr_data, output, 13, parallel pattern for the shift register.
REQ-008 SHALL have port sr_enable, output, 1, parallel-load strobe to the shift register.
REQ-009 SHALL have port sr_shift, output, 1, one-cycle shift strobe to the shift register.
REQ-010 SHALL have port led, output, 1, Morse light output.
REQ-011 SHALL have port busy, output, 1, high whenever not IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse marking the end of a letter.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD and SHOW, held in registers; all outputs SHALL be decoded from registered state only.
REQ-014 SHALL, in IDLE with start=1, latch letter into an internal register and go to LOAD; start=0 SHALL keep IDLE.
REQ-015 SHALL decode the latched letter into pattern and length, LSB sent first (1=light on, 0=off): A 0x001D/5, B 0x0157/9, C 0x05D7/11, D 0x0057/7, E 0x0001/1, F 0x0175/9, G 0x0177/9, H 0x0055/7.
REQ-016 SHALL drive sr_data with the latched letter's pattern at all times after the first start, and with 0 after reset.
REQ-017 SHALL assert sr_enable for exactly the one cycle in LOAD, then go to SHOW with unit counter=0 and bits_left=length.
REQ-018 SHALL, in SHOW, increment the 0..TICK_DIV-1 unit counter every cycle; at TICK_DIV-1 it SHALL wrap to 0, assert sr_shift that cycle and decrement bits_left.
REQ-019 SHALL, on the sr_shift cycle with bits_left=1, also assert done and return to IDLE next cycle; sr_shift also pulses on the last unit.
REQ-020 SHALL space sr_shift pulses exactly TICK_DIV cycles apart, with the first pulse TICK_DIV cycles after SHOW entry; a letter of length L SHALL occupy L*TICK_DIV cycles in SHOW.
REQ-021 SHALL drive led = sr_bit0 in SHOW and 0 in IDLE and LOAD.
REQ-022 SHALL drive busy=1 in LOAD and SHOW.
REQ-023 SHALL ignore start and letter changes while busy; there is no queueing.
REQ-024 SHALL accept a start presented in the IDLE cycle directly after done, producing back-to-back letters.
REQ-025 SHALL size the unit counter as ceil(log2(TICK_DIV)) bits and bits_left as 4 bits.

Reset
REQ-026 SHALL, while reset=1 at a clock edge, force IDLE, counter=0, bits_left=0 and latched letter=0, with priority over start.
REQ-027 SHALL hold sr_enable, sr_shift, led, busy, done and sr_data at 0 during and after reset until the next accepted start.
REQ-028 SHALL, on reset mid-letter, abort with no done pulse and no further sr_shift; the next letter SHALL require a new start.

Verification (TICK_DIV=4; start pulsed at cycle 0)
REQ-029 SHALL cover letter E: sr_enable=1 with sr_data=0x0001 at cycle 1; led follows sr_bit0 in cycles 2-5; sr_shift and done at cycle 5; busy=0 at cycle 6.
REQ-030 SHALL cover letter A: sr_data=0x001D; 5 sr_shift pulses at cycles 5, 9, 13, 17 and 21; done only at 21; led sequence from a model shift register is 1,0,1,1,1.
REQ-031 SHALL cover letter C: 11 sr_shift pulses, done at cycle 45; start=1 held throughout does not cause a restart before done; a new letter starts at cycle 46.
REQ-032 SHALL cover reset at cycle 10 during letter B: outputs 0 from cycle 11, no done, and idle until a new start.
REQ-033 SHALL cover letter changing while busy: the in-flight pattern is unchanged and a start plus letter=7 on the post-done IDLE cycle loads 0x0055.
REQ-034 SHALL sweep all letters 0..7: check each sr_data against REQ-015 and check sr_shift count equals length.
